// File: rtl/sysop_arb.sv
// Picks one exception or system-op request per cycle (oldest stage first) for the CSR/trap unit.
// Outputs are registered one cycle after acceptance; losers are dropped, and a trap redirect blocks all requests for FLUSH_CYCLES.
module sysop_arb #(
    parameter int FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_exc_valid,
    input  logic [3:0]  if_exc_cause,
    input  logic [63:0] if_pc,
    input  logic [63:0] if_tval,
    input  logic        id_exc_valid,
    input  logic [3:0]  id_exc_cause,
    input  logic [63:0] id_pc,
    input  logic [63:0] id_tval,
    input  logic        id_sys_valid,
    input  logic [4:0]  id_sys_op,
    input  logic [11:0] id_csr_addr,
    input  logic [63:0] id_sys_wdata,
    input  logic        mem_exc_valid,
    input  logic [3:0]  mem_exc_cause,
    input  logic [63:0] mem_pc,
    input  logic [63:0] mem_tval,
    input  logic        trap_en,
    output logic [4:0]  op,
    output logic [63:0] pc,
    output logic [63:0] tval,
    output logic [63:0] wdata,
    output logic        flush,
    output logic        busy
);

    localparam logic [4:0] SYSOP_RET = 5'h04;

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [4:0]  sys_op_m;

    // bit 4 of a sysop would alias the exception encoding, so it is discarded
    assign sys_op_m = id_sys_op & 5'h0F;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= '0;
            pc    <= '0;
            tval  <= '0;
            wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_en) begin
                        state <= DRAIN;
                        cnt   <= 4'(FLUSH_CYCLES - 1);
                        op    <= '0;
                    end else if (mem_exc_valid) begin
                        op    <= {1'b1, mem_exc_cause};
                        pc    <= mem_pc;
                        tval  <= mem_tval;
                        wdata <= '0;
                    end else if (id_exc_valid) begin
                        op    <= {1'b1, id_exc_cause};
                        pc    <= id_pc;
                        tval  <= id_tval;
                        wdata <= '0;
                    end else if (if_exc_valid) begin
                        op    <= {1'b1, if_exc_cause};
                        pc    <= if_pc;
                        tval  <= if_tval;
                        wdata <= '0;
                    end else if (id_sys_valid) begin
                        op    <= sys_op_m;
                        pc    <= id_pc;
                        tval  <= (sys_op_m == SYSOP_RET) ? 64'd0 : {52'd0, id_csr_addr};
                        wdata <= id_sys_wdata;
                    end else begin
                        op    <= '0;
                    end
                end
                DRAIN: begin
                    op <= '0;
                    if (cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    op    <= '0;
                end
            endcase
        end
    end

    assign busy  = (state == DRAIN);
    assign flush = trap_en | busy;

endmodule

// File: tb/tb_sysop_arb.sv
// Bench for sysop_arb: directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_sysop_arb;

    localparam int FLUSH = 3;
    localparam logic [4:0] CSR_W = 5'h01, CSR_S = 5'h02, CSR_C = 5'h03, RET = 5'h04;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_exc_valid, id_exc_valid, id_sys_valid, mem_exc_valid;
    logic [3:0]  if_exc_cause, id_exc_cause, mem_exc_cause;
    logic [63:0] if_pc, if_tval, id_pc, id_tval, id_sys_wdata, mem_pc, mem_tval;
    logic [4:0]  id_sys_op;
    logic [11:0] id_csr_addr;
    logic        trap_en;
    logic        trap_auto;
    logic [4:0]  op;
    logic [63:0] pc, tval, wdata;
    logic        flush, busy;

    int n_checks = 0;
    int n_fail   = 0;

    // stand-in for the CSR unit: every exception and RET redirects
    assign trap_en = trap_auto & (op[4] | (op == RET));

    always #5 clk = ~clk;

    sysop_arb #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_exc_valid(if_exc_valid), .if_exc_cause(if_exc_cause), .if_pc(if_pc), .if_tval(if_tval),
        .id_exc_valid(id_exc_valid), .id_exc_cause(id_exc_cause), .id_pc(id_pc), .id_tval(id_tval),
        .id_sys_valid(id_sys_valid), .id_sys_op(id_sys_op), .id_csr_addr(id_csr_addr),
        .id_sys_wdata(id_sys_wdata),
        .mem_exc_valid(mem_exc_valid), .mem_exc_cause(mem_exc_cause), .mem_pc(mem_pc), .mem_tval(mem_tval),
        .trap_en(trap_en),
        .op(op), .pc(pc), .tval(tval), .wdata(wdata), .flush(flush), .busy(busy)
    );

    task automatic clear_inputs();
        if_exc_valid = 0; id_exc_valid = 0; id_sys_valid = 0; mem_exc_valid = 0;
        if_exc_cause = 0; id_exc_cause = 0; mem_exc_cause = 0;
        if_pc = 0; if_tval = 0; id_pc = 0; id_tval = 0; id_sys_wdata = 0;
        mem_pc = 0; mem_tval = 0; id_sys_op = 0; id_csr_addr = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        trap_auto = 1;
        rst_n = 0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            n_checks += 3;
            if (op !== 5'h0) begin n_fail++; $display("FAIL reset_op cyc %0d: got %h want 00", i, op); end
            if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush cyc %0d: got %b want 0", i, flush); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, busy); end
        end
    endtask

    task automatic test_back_to_back();
        id_sys_valid = 1; id_sys_op = CSR_W; id_csr_addr = 12'h305;
        id_sys_wdata = 64'h8000_0000; id_pc = 64'h200;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            n_checks += 4;
            if (op !== CSR_W) begin n_fail++; $display("FAIL b2b_op %0d: got %h want %h", i, op, CSR_W); end
            if (tval !== 64'h305) begin n_fail++; $display("FAIL b2b_tval %0d: got %h want 305", i, tval); end
            if (wdata !== 64'h8000_0000) begin n_fail++; $display("FAIL b2b_wdata %0d: got %h want 80000000", i, wdata); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy %0d: got %b want 0", i, busy); end
        end
        clear_inputs();
        next_cycle();
        n_checks++;
        if (op !== 5'h0) begin n_fail++; $display("FAIL b2b_oneshot: got %h want 00", op); end
    endtask

    task automatic test_priority();
        mem_exc_valid = 1; mem_exc_cause = 4'd5; mem_pc = 64'h1000; mem_tval = 64'hDEAD;
        if_exc_valid = 1; if_exc_cause = 4'd1; if_pc = 64'h2000; if_tval = 64'h77;
        next_cycle();
        clear_inputs();
        n_checks += 5;
        if (op !== 5'h15) begin n_fail++; $display("FAIL prio_op: got %h want 15", op); end
        if (pc !== 64'h1000) begin n_fail++; $display("FAIL prio_pc: got %h want 1000", pc); end
        if (tval !== 64'hDEAD) begin n_fail++; $display("FAIL prio_tval: got %h want dead", tval); end
        if (wdata !== 64'h0) begin n_fail++; $display("FAIL prio_wdata: got %h want 0", wdata); end
        if (flush !== 1'b1) begin n_fail++; $display("FAIL prio_flush: got %b want 1", flush); end
        repeat (FLUSH + 2) next_cycle();
        n_checks++;
        if (op !== 5'h0) begin n_fail++; $display("FAIL prio_if_dropped: got %h want 00", op); end
    endtask

    task automatic test_exc_drain();
        int flush_cnt = 0, busy_cnt = 0;
        id_exc_valid = 1; id_exc_cause = 4'd2; id_pc = 64'h3000; id_tval = 64'h1234;
        next_cycle();
        clear_inputs();
        id_sys_valid = 1; id_sys_op = CSR_C; id_csr_addr = 12'h300;
        n_checks++;
        if (op !== 5'h12) begin n_fail++; $display("FAIL drain_exc_op: got %h want 12", op); end
        if (flush) flush_cnt++;
        for (int i = 0; i < FLUSH; i++) begin
            next_cycle();
            if (flush) flush_cnt++;
            if (busy) busy_cnt++;
            n_checks++;
            if (op !== 5'h0) begin n_fail++; $display("FAIL drain_sys_blocked %0d: got %h want 00", i, op); end
        end
        id_sys_valid = 0;
        next_cycle();
        if (flush) flush_cnt++;
        if (busy) busy_cnt++;
        n_checks += 3;
        if (flush_cnt !== 1 + FLUSH) begin n_fail++; $display("FAIL drain_flush_len: got %0d want %0d", flush_cnt, 1 + FLUSH); end
        if (busy_cnt !== FLUSH) begin n_fail++; $display("FAIL drain_busy_len: got %0d want %0d", busy_cnt, FLUSH); end
        if (op !== 5'h0) begin n_fail++; $display("FAIL drain_after: got %h want 00", op); end
    endtask

    task automatic test_ret_drain();
        id_sys_valid = 1; id_sys_op = RET; id_pc = 64'h4000; id_csr_addr = 12'h341;
        next_cycle();
        n_checks += 3;
        if (op !== RET) begin n_fail++; $display("FAIL ret_op: got %h want %h", op, RET); end
        if (tval !== 64'h0) begin n_fail++; $display("FAIL ret_tval: got %h want 0", tval); end
        if (flush !== 1'b1) begin n_fail++; $display("FAIL ret_flush: got %b want 1", flush); end
        id_sys_op = CSR_S; id_csr_addr = 12'h300; id_sys_wdata = 64'h8;
        repeat (FLUSH) next_cycle();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ret_busy_last: got %b want 1", busy); end
        next_cycle();
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL ret_idle: got %b want 0", busy); end
        if (op !== 5'h0) begin n_fail++; $display("FAIL ret_exit_ignored: got %h want 00", op); end
        next_cycle();
        id_sys_valid = 0;
        n_checks += 2;
        if (op !== CSR_S) begin n_fail++; $display("FAIL ret_csr_s_op: got %h want %h", op, CSR_S); end
        if (tval !== 64'h300) begin n_fail++; $display("FAIL ret_csr_s_tval: got %h want 300", tval); end
        next_cycle();
    endtask

    task automatic test_reset_mid_drain();
        id_exc_valid = 1; id_exc_cause = 4'd3; id_pc = 64'h5000;
        next_cycle();
        clear_inputs();
        n_checks++;
        if (op !== 5'h13) begin n_fail++; $display("FAIL rmd_op: got %h want 13", op); end
        repeat (2) next_cycle();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rmd_busy_before: got %b want 1", busy); end
        rst_n = 0;
        #1;
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rmd_busy: got %b want 0", busy); end
        if (flush !== 1'b0) begin n_fail++; $display("FAIL rmd_flush: got %b want 0", flush); end
        if (op !== 5'h0) begin n_fail++; $display("FAIL rmd_op_clear: got %h want 00", op); end
        @(negedge clk);
        rst_n = 1;
        id_exc_valid = 1; id_exc_cause = 4'd2; id_pc = 64'h6000; id_tval = 64'h99;
        next_cycle();
        clear_inputs();
        n_checks += 2;
        if (op !== 5'h12) begin n_fail++; $display("FAIL rmd_new_op: got %h want 12", op); end
        if (pc !== 64'h6000) begin n_fail++; $display("FAIL rmd_new_pc: got %h want 6000", pc); end
        repeat (FLUSH + 2) next_cycle();
    endtask

    // reference model: one accepted request per cycle, oldest stage wins, traps block FLUSH cycles
    task automatic test_random();
        int m_drain = 0;
        logic [4:0]  m_op = 5'h0;
        logic [63:0] m_pc = 0, m_tval = 0, m_wdata = 0;
        logic [4:0]  sys_ops [4] = '{CSR_W, CSR_S, CSR_C, RET};
        bit m_trap;
        for (int i = 0; i < 400; i++) begin
            mem_exc_valid = ($urandom_range(0, 7) == 0);
            id_exc_valid  = ($urandom_range(0, 7) == 0);
            if_exc_valid  = ($urandom_range(0, 7) == 0);
            id_sys_valid  = ($urandom_range(0, 2) == 0);
            mem_exc_cause = 4'($urandom); id_exc_cause = 4'($urandom); if_exc_cause = 4'($urandom);
            mem_pc = {$urandom, $urandom}; mem_tval = {$urandom, $urandom};
            id_pc  = {$urandom, $urandom}; id_tval  = {$urandom, $urandom};
            if_pc  = {$urandom, $urandom}; if_tval  = {$urandom, $urandom};
            id_sys_op = sys_ops[$urandom_range(0, 3)] | (($urandom_range(0, 3) == 0) ? 5'h10 : 5'h00);
            id_csr_addr = 12'($urandom); id_sys_wdata = {$urandom, $urandom};
            @(posedge clk);
            m_trap = m_op[4] || (m_op == RET);
            if (m_drain > 0) begin
                m_drain--; m_op = 0;
            end else if (m_trap) begin
                m_drain = FLUSH; m_op = 0;
            end else if (mem_exc_valid) begin
                m_op = {1'b1, mem_exc_cause}; m_pc = mem_pc; m_tval = mem_tval; m_wdata = 0;
            end else if (id_exc_valid) begin
                m_op = {1'b1, id_exc_cause}; m_pc = id_pc; m_tval = id_tval; m_wdata = 0;
            end else if (if_exc_valid) begin
                m_op = {1'b1, if_exc_cause}; m_pc = if_pc; m_tval = if_tval; m_wdata = 0;
            end else if (id_sys_valid) begin
                m_op = {1'b0, id_sys_op[3:0]}; m_pc = id_pc; m_wdata = id_sys_wdata;
                m_tval = (m_op == RET) ? 64'h0 : {52'h0, id_csr_addr};
            end else begin
                m_op = 0;
            end
            @(negedge clk);
            n_checks += 3;
            if (op !== m_op) begin n_fail++; $display("FAIL rnd_op cyc %0d: got %h want %h", i, op, m_op); end
            if (busy !== (m_drain > 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %b want %b", i, busy, m_drain > 0); end
            if (flush !== ((m_drain > 0) || m_op[4] || (m_op == RET))) begin
                n_fail++; $display("FAIL rnd_flush cyc %0d: got %b", i, flush);
            end
            if (m_op != 0) begin
                n_checks += 3;
                if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc cyc %0d: got %h want %h", i, pc, m_pc); end
                if (tval !== m_tval) begin n_fail++; $display("FAIL rnd_tval cyc %0d: got %h want %h", i, tval, m_tval); end
                if (wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc %0d: got %h want %h", i, wdata, m_wdata); end
            end
        end
        clear_inputs();
        repeat (FLUSH + 2) next_cycle();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_priority();
        test_exc_drain();
        test_ret_drain();
        test_reset_mid_drain();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sysop_arb.md
Name: sysop_arb

Overview:
- Arbitration stage directly upstream of the CSR/trap unit.
- Collects exception requests from fetch, decode and memory stages, plus non-exception system ops from decode (CSR write/set/clear, RET).
- Selects one request per cycle by age priority and drives the CSR unit's op/pc/tval/wdata inputs from registers.
- Drains wrong-path requests for a fixed window after every trap redirect.

Parameters:
FLUSH_CYCLES, 3, cycles of DRAIN after a trap redirect; legal range 1..15.

Ports:
clk  input  1  core clock
rst_n  input  1  reset, asynchronous, active-low
if_exc_valid  input  1  fetch-stage exception request
if_exc_cause  input  4  fetch exception cause
if_pc  input  64  fetch faulting pc
if_tval  input  64  fetch trap value
id_exc_valid  input  1  decode-stage exception request (illegal, ecall, ebreak)
id_exc_cause  input  4  decode exception cause
id_pc  input  64  decode pc, shared by exception and sysop requests
id_tval  input  64  decode trap value
id_sys_valid  input  1  decode non-exception sysop request
id_sys_op  input  5  SYSOP_CSR_W/S/C or SYSOP_RET; bit 4 always 0
id_csr_addr  input  12  CSR index for CSR ops
id_sys_wdata  input  64  CSR write operand
mem_exc_valid  input  1  memory-stage exception request
mem_exc_cause  input  4  memory exception cause
mem_pc  input  64  memory faulting pc
mem_tval  input  64  memory fault address
trap_en  input  1  redirect indication from the CSR unit, combinational from op
op  output  5  to CSR unit; 5'b0 = no operation; exception = {1'b1, cause}
pc  output  64  to CSR unit
tval  output  64  to CSR unit; for CSR ops = {52'b0, id_csr_addr}
wdata  output  64  to CSR unit
flush  output  1  kill younger in-flight instructions
busy  output  1  high while in DRAIN

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0, op/pc/tval/wdata = 0, busy = 0.
- flush is combinational: trap_en | (state == DRAIN). It is therefore 0 during reset.
- Priority, fixed, oldest first:
  - mem_exc > id_exc > if_exc > id_sys.
  - Exactly one request is accepted per cycle; all lower-priority requests that cycle are dropped, not queued. Stages re-present if still valid.
- Latency: a request accepted at edge N appears on op/pc/tval/wdata during cycle N..N+1.
  - op is one-shot: it returns to 0 at the next edge unless a new request is accepted.
  - Back-to-back CSR ops are issued on consecutive cycles.
- Field mapping:
  - Exception: op = {1, cause}; pc and tval from the winning stage; wdata = 0.
  - Sysop: op = id_sys_op; pc = id_pc; wdata = id_sys_wdata; tval = zero-extended id_csr_addr. For RET, tval = 0.
- IDLE:
  - If trap_en = 1 this cycle (exception, RET or invalid SATP write issued last edge), all inputs are ignored.
  - Next state is DRAIN, counter = FLUSH_CYCLES-1, op <= 0.
  - Otherwise, accept the highest-priority request.
- DRAIN:
  - All inputs are ignored; op <= 0; busy = 1.
  - Counter decrements each cycle; at counter 0, next state is IDLE.
  - With FLUSH_CYCLES = 1, DRAIN lasts exactly one cycle.
- trap_en during DRAIN: has no effect, since op is 0 there.
- Reset asserted mid-DRAIN returns immediately to IDLE with all outputs cleared; any pending request is lost.
- id_sys_valid with id_sys_op[4] = 1 is illegal input; the op is forced to bit 4 = 0 (ignore bit 4).
- Timing: no combinational path from any *_valid input to op.

Test Plan:
- Reset release, all inputs 0 -> op = 0, flush = 0, busy = 0 for 10 cycles.
- id_sys_valid with CSR_W, addr 0x305, wdata 0x8000_0000, for 2 consecutive cycles -> op = CSR_W on 2 consecutive cycles, tval = 0x305, wdata = 0x8000_0000; no DRAIN.
- Same-cycle mem_exc (cause 5, pc 0x1000, tval 0xDEAD) and if_exc (cause 1) -> op = 5'h15, pc = 0x1000, tval = 0xDEAD; the if request is dropped.
- Exception issued with trap_en driven 1 in the op cycle -> flush = 1 for 1+FLUSH_CYCLES (4) cycles, busy = 1 for 3 cycles; id_sys requests during that window are never issued.
- RET with trap_en = 1, then id_sys CSR_S held valid -> CSR_S issued on the first cycle after DRAIN ends.
- rst_n pulsed low during DRAIN cycle 2 -> busy, flush and op are 0 immediately; after release, a new id_exc is issued with 1-cycle latency.
